clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter N_CH, default 3, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 26, width of each half-period counter and divisor.
REQ-003 Parameter DEF_HALF, default {26'd125000, 26'd25000000, 26'd50000000} (ch2..ch0), N_CH*CNT_W packed reset half-periods; ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 400 Hz at 100 MHz.
REQ-004 Local constant CH_W = max(1, clog2(N_CH)).
REQ-005 sclk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  N_CH  per-channel run enable.
REQ-008 sync_clr  input  1  synchronous phase-align clear of all channels.
REQ-009 div_wr  input  1  one-cycle divisor write strobe.
REQ-010 div_ch  input  CH_W  channel index for div_wr.
REQ-011 div_val  input  CNT_W  new half-period in sclk cycles.
REQ-012 sq  output  N_CH  registered 50 % duty square outputs.
REQ-013 tick  output  N_CH  registered one-cycle pulse per output period.
REQ-014 half_rd  output  N_CH*CNT_W  active half-period of each channel.

Function
REQ-015 Each channel SHALL hold an active half-period H, a pending value P with a pending flag, a counter C, and sq.
REQ-016 While en[c]=1 and H>=1, C SHALL increment every cycle; at C==H-1 (terminal) C SHALL return to 0 and sq[c] SHALL toggle on the same edge.
REQ-017 tick[c] SHALL be 1 for exactly the cycle following each terminal at which sq[c] goes 0->1, giving one pulse per 2*H cycles.
REQ-018 First sq[c] rising edge after reset or enable SHALL occur H cycles after counting starts.
REQ-019 div_wr with div_ch < N_CH SHALL load P[div_ch] and set its pending flag; div_ch >= N_CH SHALL be ignored.
REQ-020 An enabled channel SHALL commit P to H only at a terminal, so no half-period is truncated; a write in the terminal cycle itself SHALL commit at that terminal.
REQ-021 A disabled channel SHALL commit P to H on the edge following the write.
REQ-022 Repeated writes before commit SHALL keep only the latest value.
REQ-023 H==0 SHALL freeze the channel: C=0, sq=0, tick=0.
REQ-024 en[c]=0 SHALL force C=0, sq[c]=0, tick[c]=0 on the next edge; re-enable restarts per REQ-018.
REQ-025 sync_clr=1 SHALL force C=0, sq=0, tick=0 on all channels on the next edge, keep H and pending P, and take priority over terminal and commit.
REQ-026 half_rd SHALL reflect H for each channel, not P.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W bits; C never exceeds H-1, so no wrap occurs.

Reset
REQ-028 rst=1 SHALL immediately set C=0, sq=0, tick=0, pending flags=0, H=P=DEF_HALF slice for every channel.
REQ-029 Reset mid-period SHALL discard the partial period and any pending write.

Structure
REQ-030 Default half-period constants and CH_W computation SHALL live in the shared clk_pkg header.
REQ-031 One sub-module, clk_div_ch, SHALL implement a single channel and be instantiated N_CH times by generate.

Verification
REQ-032 N_CH=3, CNT_W=8, ch0 H=3, en=001 -> sq[0] rises at cycles 3, 9, 15; tick[0] high at 4, 10, 16.
REQ-033 ch0 H=3 running, div_val=5 written at cycle 1 -> next half-period stays 3, then sq[0] toggles every 5 cycles.
REQ-034 Write in terminal cycle (cycle 2, H=3, val=2) -> following half-period is 2 cycles.
REQ-035 div_ch=3 write -> all half_rd unchanged; H=0 on ch1 -> sq[1], tick[1] stay 0.
REQ-036 sync_clr at cycle 7 with ch0 H=3, ch1 H=4 -> both sq drop to 0, both rise together 3 and 4 cycles later respectively.
REQ-037 rst asserted mid-count, asynchronously between edges -> sq=0, tick=0 immediately; half_rd = DEF_HALF.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared constants for the multi-channel clock divider: reset half-periods
// for the default three-channel build and the channel-index width helper.
package clk_pkg;

  localparam int DEF_N_CH  = 3;
  localparam int DEF_CNT_W = 26;

  // ch2..ch0 reset half-periods at 100 MHz: 400 Hz, 2 Hz, 1 Hz.
  localparam logic [DEF_N_CH*DEF_CNT_W-1:0] DEF_HALF_3CH =
    {26'd125000, 26'd25000000, 26'd50000000};

  // Channel-select width; a single-channel build still gets a 1-bit select.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, square output, rising-edge tick,
// and an active/pending half-period pair that only swaps at a safe point.
module clk_div_ch
  import clk_pkg::*;
#(
  parameter int               CNT_W = 26,
  parameter logic [CNT_W-1:0] DEF   = CNT_W'(1)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             sq,
  output logic             tick,
  output logic [CNT_W-1:0] half
);

  logic [CNT_W-1:0] h;       // active half-period
  logic [CNT_W-1:0] p;       // pending half-period
  logic             pend;
  logic [CNT_W-1:0] c;       // position inside the current half-period
  logic             rise;    // sq rose on the previous edge; tick follows it

  logic             run;
  logic             term;
  logic             do_commit;
  logic [CNT_W-1:0] commit_val;

  // A zero half-period parks the channel exactly like a disable.
  assign run  = en && (h != '0);
  assign term = run && (c == h - CNT_W'(1));

  // A write arriving in the terminal cycle wins over the older pending value.
  assign commit_val = wr ? wr_val : p;
  // Idle channels commit at once; running ones only at a terminal so the
  // half-period in flight is never cut short. A clear defers the commit.
  assign do_commit  = !sync_clr && (wr || pend) && (!run || term);

  assign half = h;

  // Divisor registers: latch writes into P, move P into H on commit.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking = would leak new values into later statements.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      h    <= DEF;
      p    <= DEF;
      pend <= 1'b0;
    end else if (do_commit) begin
      h    <= commit_val;
      p    <= commit_val;
      pend <= 1'b0;
    end else if (wr) begin
      p    <= wr_val;
      pend <= 1'b1;
    end
  end

  // Counter and outputs: count to H-1, toggle sq, tick one cycle after a rise.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      c    <= '0;
      sq   <= 1'b0;
      rise <= 1'b0;
      tick <= 1'b0;
    end else if (sync_clr || !run) begin
      c    <= '0;
      sq   <= 1'b0;
      rise <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= rise;
      if (term) begin
        c    <= '0;
        sq   <= ~sq;
        rise <= ~sq;
      end else begin
        c    <= c + CNT_W'(1);
        rise <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent square-wave dividers sharing one divisor write port.
module clk_div_multi
  import clk_pkg::*;
#(
  parameter  int                      N_CH     = DEF_N_CH,
  parameter  int                      CNT_W    = DEF_CNT_W,
  parameter  logic [N_CH*CNT_W-1:0]   DEF_HALF = DEF_HALF_3CH,
  localparam int                      CH_W     = ch_width(N_CH)
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync_clr,
  input  logic                  div_wr,
  input  logic [CH_W-1:0]       div_ch,
  input  logic [CNT_W-1:0]      div_val,
  output logic [N_CH-1:0]       sq,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*CNT_W-1:0] half_rd
);

  // One channel per slice; out-of-range div_ch matches no channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = div_wr && (div_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W (CNT_W),
      .DEF   (DEF_HALF[i*CNT_W +: CNT_W])
    ) u_ch (
      .sclk     (sclk),
      .rst      (rst),
      .en       (en[i]),
      .sync_clr (sync_clr),
      .wr       (wr_hit),
      .wr_val   (div_val),
      .sq       (sq[i]),
      .tick     (tick[i]),
      .half     (half_rd[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: event-scheduled reference model compared every
// cycle, plus directed scenarios with hand-computed edge positions.
module tb_clk_div_multi;

  localparam int            N_CH  = 3;
  localparam int            CNT_W = 8;
  localparam logic [23:0]   DEF   = {8'd5, 8'd4, 8'd3};

  logic        sclk;
  logic        rst;
  logic [2:0]  en;
  logic        sync_clr;
  logic        div_wr;
  logic [1:0]  div_ch;
  logic [7:0]  div_val;
  logic [2:0]  sq;
  logic [2:0]  tick;
  logic [23:0] half_rd;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  clk_div_multi #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .sq       (sq),
    .tick     (tick),
    .half_rd  (half_rd)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (toggle-deadline scheduling) ----------
  int m_h[3], m_p[3], m_pend[3], m_idle[3], m_flip[3], m_sq[3], m_tick_at[3];

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      m_h[c]       = int'(DEF[c*8 +: 8]);
      m_p[c]       = m_h[c];
      m_pend[c]    = 0;
      m_idle[c]    = 1;
      m_flip[c]    = 0;
      m_sq[c]      = 0;
      m_tick_at[c] = -1;
    end
  endtask

  initial begin : monitor
    int         n;
    logic [2:0] s_en;
    logic       s_clr, s_wr;
    logic [1:0] s_ch;
    logic [7:0] s_val;
    logic [2:0] e_sq, e_tick;
    logic [23:0] e_half;
    n = 0;
    m_reset();
    forever begin
      @(posedge sclk);
      n++;
      s_en = en; s_clr = sync_clr; s_wr = div_wr; s_ch = div_ch; s_val = div_val;
      if (rst) begin
        m_reset();
      end else begin
        for (int c = 0; c < 3; c++) begin
          bit hit;
          hit = s_wr && (int'(s_ch) == c);
          if (s_clr) begin
            m_idle[c] = 1; m_sq[c] = 0; m_tick_at[c] = -1;
            if (hit) begin m_p[c] = int'(s_val); m_pend[c] = 1; end
          end else if (!s_en[c] || m_h[c] == 0) begin
            m_idle[c] = 1; m_sq[c] = 0; m_tick_at[c] = -1;
            if (hit) begin m_p[c] = int'(s_val); m_pend[c] = 1; end
            if (m_pend[c] != 0) begin m_h[c] = m_p[c]; m_pend[c] = 0; end
          end else begin
            // Counting starts on this edge: first toggle lands H edges after
            // the start of cycle 0, i.e. on edge n+H-1.
            if (m_idle[c] != 0) begin m_idle[c] = 0; m_flip[c] = n + m_h[c] - 1; end
            if (hit) begin m_p[c] = int'(s_val); m_pend[c] = 1; end
            if (n == m_flip[c]) begin
              m_sq[c] = 1 - m_sq[c];
              if (m_sq[c] != 0) m_tick_at[c] = n + 1;
              if (m_pend[c] != 0) begin m_h[c] = m_p[c]; m_pend[c] = 0; end
              m_flip[c] = n + m_h[c];
            end
          end
        end
      end
      #1;
      for (int c = 0; c < 3; c++) begin
        e_sq[c]          = (m_sq[c] != 0);
        e_tick[c]        = (m_tick_at[c] == n);
        e_half[c*8 +: 8] = 8'(m_h[c]);
      end
      if (!done) begin
        check($sformatf("mon_sq_e%0d", n),   {29'd0, sq},   {29'd0, e_sq});
        check($sformatf("mon_tick_e%0d", n), {29'd0, tick}, {29'd0, e_tick});
        check($sformatf("mon_half_e%0d", n), {8'd0, half_rd}, {8'd0, e_half});
      end
    end
  end

  // ---------------- directed stimulus with recorded histories -------------
  logic [2:0]  sq_h [0:31];
  logic [2:0]  tk_h [0:31];
  logic [23:0] hr_h [0:31];

  // Called right after a negedge. Cycle 0 is the first cycle driven here;
  // entry k+1 holds outputs after the (k+1)-th edge.
  task automatic run_rec(input int n, input logic [2:0] e, input int wc,
                         input logic [1:0] wch, input logic [7:0] wval, input int cc);
    sq_h[0] = sq; tk_h[0] = tick; hr_h[0] = half_rd;
    for (int k = 0; k < n; k++) begin
      en       = e;
      div_wr   = (k == wc);
      div_ch   = wch;
      div_val  = wval;
      sync_clr = (k == cc);
      @(posedge sclk);
      #1;
      sq_h[k+1] = sq; tk_h[k+1] = tick; hr_h[k+1] = half_rd;
      @(negedge sclk);
    end
    div_wr   = 1'b0;
    sync_clr = 1'b0;
  endtask

  // Asserts reset between edges; optionally checks the immediate effect.
  task automatic do_reset(input bit chk);
    #2;
    rst = 1'b1; en = '0; div_wr = 1'b0; sync_clr = 1'b0;
    if (chk) begin
      #1;
      check("rst_async_sq",   {29'd0, sq},   32'd0);
      check("rst_async_tick", {29'd0, tick}, 32'd0);
      check("rst_async_half", {8'd0, half_rd}, {8'd0, DEF});
    end
    @(negedge sclk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rise_of(input int c, input int n);
    logic [31:0] m = '0;
    for (int k = 1; k <= n; k++) if (sq_h[k][c] && !sq_h[k-1][c]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] toggle_of(input int c, input int n);
    logic [31:0] m = '0;
    for (int k = 1; k <= n; k++) if (sq_h[k][c] != sq_h[k-1][c]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] tick_of(input int c, input int n);
    logic [31:0] m = '0;
    for (int k = 0; k <= n; k++) if (tk_h[k][c]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] sq_of(input int c, input int n);
    logic [31:0] m = '0;
    for (int k = 0; k <= n; k++) if (sq_h[k][c]) m[k] = 1'b1;
    return m;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1; en = '0; sync_clr = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    #7;
    check("reset_sq",   {29'd0, sq},   32'd0);
    check("reset_tick", {29'd0, tick}, 32'd0);
    check("reset_half", {8'd0, half_rd}, {8'd0, DEF});
    @(negedge sclk);
    rst = 1'b0;

    // H=3 free-running: rises at 3, 9, 15; ticks at 4, 10, 16.
    run_rec(17, 3'b001, -1, 2'd0, 8'd0, -1);
    check("basic_rise_ch0", rise_of(0, 17), 32'h0000_8208);
    check("basic_tick_ch0", tick_of(0, 17), 32'h0001_0410);

    // Write 5 during the first half-period: toggles at 3, then every 5.
    do_reset(1'b0);
    run_rec(20, 3'b001, 1, 2'd0, 8'd5, -1);
    check("wr_mid_toggles", toggle_of(0, 20), 32'h0004_2108);
    check("wr_mid_half_pend", {24'd0, hr_h[2][7:0]}, 32'd3);
    check("wr_mid_half_commit", {24'd0, hr_h[3][7:0]}, 32'd5);

    // Write 2 in the terminal cycle: toggles at 3, 5, 7, 9.
    do_reset(1'b0);
    run_rec(10, 3'b001, 2, 2'd0, 8'd2, -1);
    check("wr_term_toggles", toggle_of(0, 10), 32'h0000_02A8);

    // Out-of-range channel ignored; idle commit is immediate; H=0 freezes.
    do_reset(1'b0);
    run_rec(3, 3'b000, 1, 2'd3, 8'd9, -1);
    check("bad_ch_half", {8'd0, hr_h[3]}, {8'd0, DEF});
    run_rec(3, 3'b000, 0, 2'd1, 8'd0, -1);
    check("idle_commit_half", {8'd0, hr_h[1]}, 32'h0005_0003);
    run_rec(20, 3'b111, -1, 2'd0, 8'd0, -1);
    check("h0_sq_ch1",   sq_of(1, 20),   32'd0);
    check("h0_tick_ch1", tick_of(1, 20), 32'd0);
    check("h0_rise_ch0", rise_of(0, 20), 32'h0000_8208);
    check("h0_rise_ch2", rise_of(2, 20), 32'h0000_8020);

    // sync_clr at cycle 7: both low after edge 8, rise again at 11 and 12.
    do_reset(1'b0);
    run_rec(20, 3'b011, -1, 2'd0, 8'd0, 7);
    check("clr_ch1_high_before", {31'd0, sq_h[7][1]}, 32'd1);
    check("clr_sq_low", {30'd0, sq_h[8][1:0]}, 32'd0);
    check("clr_rise_ch0", rise_of(0, 20), 32'h0002_0808);
    check("clr_rise_ch1", rise_of(1, 20), 32'h0010_1010);

    // Disable mid-count, then re-enable: first rise 3 cycles after restart.
    do_reset(1'b0);
    run_rec(4, 3'b001, -1, 2'd0, 8'd0, -1);
    run_rec(2, 3'b000, -1, 2'd0, 8'd0, -1);
    check("dis_sq_low", {29'd0, sq_h[2]}, 32'd0);
    run_rec(5, 3'b001, -1, 2'd0, 8'd0, -1);
    check("reen_rise_ch0", rise_of(0, 5), 32'h0000_0008);

    // Async reset mid-count discards committed and pending divisors.
    do_reset(1'b0);
    run_rec(5, 3'b111, 0, 2'd2, 8'd7, -1);
    run_rec(2, 3'b111, 1, 2'd0, 8'd9, -1);
    check("pre_rst_half", {8'd0, half_rd}, 32'h0007_0403);
    check("pre_rst_busy", {31'd0, (sq != 3'b000)}, 32'd1);
    do_reset(1'b1);
    run_rec(8, 3'b001, -1, 2'd0, 8'd0, -1);
    check("post_rst_rise_ch0", rise_of(0, 8), 32'h0000_0008);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
